// File: rtl/shift_arb_ctrl_pkg.sv
// ============================================================================
// Module      : shift_arb_ctrl_pkg
// Description : Shared op/state encodings and helpers for shift_arb_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_arb_ctrl_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned AMT_W  = 3;

    typedef enum logic [1:0] {
        OP_SHL = 2'b00,
        OP_SHR = 2'b01,
        OP_ROL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PASS1 = 2'b01,
        S_PASS2 = 2'b10,
        S_RESP  = 2'b11
    } state_e;

    function automatic logic op_is_right(input op_e op);
        return (op == OP_SHR) || (op == OP_ROR);
    endfunction

    function automatic logic op_is_rot(input op_e op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_SHREYANSHU.sv
// ============================================================================
// Module      : barrel_SHREYANSHU
// Description : Combinational 8-bit logical barrel shifter, zero fill.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_SHREYANSHU
    import shift_arb_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [AMT_W-1:0]  b_i,
    input  logic              r_i,
    output logic [DATA_W-1:0] y_o
);

    assign y_o = r_i ? (a_i >> b_i) : (a_i << b_i);

endmodule

`default_nettype wire

// File: rtl/shift_arb_ctrl.sv
// ============================================================================
// Module      : shift_arb_ctrl
// Description : Two-requester arbiter/sequencer for the shared barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_arb_ctrl
    import shift_arb_ctrl_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic [1:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    input  logic [1:0]        req1_op,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    input  logic              rsp1_ready,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic              gnt_q, gnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [AMT_W-1:0]  amt_q, amt_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;

    logic              w_any_valid;
    logic              w_gnt_id;
    logic              w_accept;
    logic [AMT_W-1:0]  w_sh_b;
    logic              w_sh_r;
    logic [DATA_W-1:0] w_sh_y;
    logic              w_rsp_ready;

    // Grant: a lone requester wins outright; a tie goes to the rr pointer.
    assign w_any_valid = req0_valid || req1_valid;
    assign w_gnt_id    = (req0_valid && req1_valid) ? (FIXED_PRIO ? 1'b0 : rr_q)
                                                    : req1_valid;
    assign w_accept    = (state_q == S_IDLE) && w_any_valid;
    assign req0_ready  = w_accept && !w_gnt_id;
    assign req1_ready  = w_accept &&  w_gnt_id;

    // Second pass shifts the other way by (8-amt) to recover wrapped bits.
    assign w_sh_b = (state_q == S_PASS2) ? (3'd0 - amt_q) : amt_q;
    assign w_sh_r = op_is_right(op_q) ^ (state_q == S_PASS2);

    barrel_SHREYANSHU u_barrel (
        .a_i (data_q),
        .b_i (w_sh_b),
        .r_i (w_sh_r),
        .y_o (w_sh_y)
    );

    assign w_rsp_ready = gnt_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        data_d      = data_q;
        amt_d       = amt_q;
        op_d        = op_q;
        acc_d       = acc_q;
        rsp0_data_d = rsp0_data_q;
        rsp1_data_d = rsp1_data_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    gnt_d   = w_gnt_id;
                    data_d  = w_gnt_id ? req1_data : req0_data;
                    amt_d   = w_gnt_id ? req1_amt  : req0_amt;
                    op_d    = op_e'(w_gnt_id ? req1_op : req0_op);
                    state_d = S_PASS1;
                end
            end
            S_PASS1: begin
                acc_d = w_sh_y;
                if (op_is_rot(op_q) && (amt_q != '0)) begin
                    state_d = S_PASS2;
                end else begin
                    state_d = S_RESP;
                    if (gnt_q) rsp1_data_d = w_sh_y;
                    else       rsp0_data_d = w_sh_y;
                end
            end
            S_PASS2: begin
                acc_d   = acc_q | w_sh_y;
                state_d = S_RESP;
                if (gnt_q) rsp1_data_d = acc_q | w_sh_y;
                else       rsp0_data_d = acc_q | w_sh_y;
            end
            S_RESP: begin
                if (w_rsp_ready) begin
                    state_d = S_IDLE;
                    rr_d    = !gnt_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_q        <= 1'b0;
            gnt_q       <= 1'b0;
            data_q      <= '0;
            amt_q       <= '0;
            op_q        <= OP_SHL;
            acc_q       <= '0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            data_q      <= data_d;
            amt_q       <= amt_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            rsp0_data_q <= rsp0_data_d;
            rsp1_data_q <= rsp1_data_d;
        end
    end

    assign rsp0_valid = (state_q == S_RESP) && !gnt_q;
    assign rsp1_valid = (state_q == S_RESP) &&  gnt_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shift_arb_ctrl.sv
// ============================================================================
// Module      : tb_shift_arb_ctrl
// Description : Directed scoreboard bench for shift_arb_ctrl (both modes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic [2:0] req0_amt, req1_amt;
    logic [1:0] req0_op, req1_op;
    logic       rsp0_ready, rsp1_ready;

    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [7:0] rsp0_data, rsp1_data;
    logic       fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy;
    logic [7:0] fp_rsp0_data, fp_rsp1_data;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [8:0] sb_q[$];

    always #5 clk = ~clk;

    shift_arb_ctrl #(.FIXED_PRIO(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
        .busy(busy)
    );

    shift_arb_ctrl #(.FIXED_PRIO(1'b1)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_op(req1_op),
        .rsp0_valid(fp_rsp0_valid), .rsp0_data(fp_rsp0_data), .rsp0_ready(rsp0_ready),
        .rsp1_valid(fp_rsp1_valid), .rsp1_data(fp_rsp1_data), .rsp1_ready(rsp1_ready),
        .busy(fp_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: rotates taken from a doubled operand, independent of the two-pass scheme.
    function automatic logic [7:0] model(input logic [1:0] op, input logic [2:0] amt,
                                         input logic [7:0] d);
        logic [15:0] dd;
        dd = {d, d};
        case (op)
            2'b00:   model = d << amt;
            2'b01:   model = d >> amt;
            2'b10:   begin dd = dd << amt; model = dd[15:8]; end
            default: begin dd = dd >> amt; model = dd[7:0];  end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_txn(input bit id, input logic [1:0] op, input logic [2:0] amt,
                           input logic [7:0] d, input int hold);
        int         cnt;
        int         exp_lat;
        logic [8:0] e;
        logic [7:0] held;
        if (id) begin req1_op = op; req1_amt = amt; req1_data = d; req1_valid = 1'b1; end
        else    begin req0_op = op; req0_amt = amt; req0_data = d; req0_valid = 1'b1; end
        #1;
        cnt = 0;
        while (!(id ? req1_ready : req0_ready) && cnt < 20) begin tick(); cnt++; end
        chk("accept_wait", (cnt < 20), 1);
        sb_q.push_back({id, model(op, amt, d)});
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        cnt = 0;
        while (!(id ? rsp1_valid : rsp0_valid) && cnt < 10) begin tick(); cnt++; end
        exp_lat = (op[1] && amt != 3'd0) ? 3 : 2;
        chk("latency", cnt + 1, exp_lat);
        chk("other_rsp_valid", id ? rsp0_valid : rsp1_valid, 0);
        e = sb_q.pop_front();
        chk("rsp_data", id ? rsp1_data : rsp0_data, e[7:0]);
        held = id ? rsp1_data : rsp0_data;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_data", id ? rsp1_data : rsp0_data, held);
            chk("hold_valid", id ? rsp1_valid : rsp0_valid, 1);
            chk("hold_other_ready", id ? req0_ready : req1_ready, 0);
        end
        if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        if (id) rsp1_ready = 1'b0; else rsp0_ready = 1'b0;
        chk("idle_after_hs", busy, 0);
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; req0_amt = '0; req1_amt = '0;
        req0_op = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        chk("rst_rsp_data", {rsp0_data, rsp1_data}, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        run_txn(1'b0, 2'b00, 3'd3, 8'hB5, 0);   // SHL -> A8
        run_txn(1'b1, 2'b11, 3'd3, 8'hB5, 0);   // ROR -> B6
        run_txn(1'b0, 2'b10, 3'd0, 8'h3C, 0);   // ROL amt 0 -> single pass
        run_txn(1'b1, 2'b01, 3'd7, 8'h81, 0);
        run_txn(1'b0, 2'b10, 3'd1, 8'h81, 0);
        run_txn(1'b1, 2'b11, 3'd7, 8'h6D, 0);

        // Response back-pressure with a competing request pending.
        req1_op = 2'b00; req1_amt = 3'd1; req1_data = 8'h55; req1_valid = 1'b1;
        run_txn(1'b0, 2'b01, 3'd2, 8'hF0, 5);
        chk("req1_after_hs", req1_ready, 1);
        run_txn(1'b1, 2'b00, 3'd1, 8'h55, 0);

        // Continuous contention: round-robin vs fixed-priority instance.
        reset_pulse();
        req0_op = 2'b00; req0_amt = 3'd1; req0_data = 8'h01;
        req1_op = 2'b00; req1_amt = 3'd2; req1_data = 8'h01;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        chk("tie_one_ready", 32'(req0_ready) + 32'(req1_ready), 1);
        g = 0;
        for (int c = 0; c < 30; c++) begin
            if (req0_ready || req1_ready) begin
                if (g < 6) chk("rr_grant", {req0_ready, req1_ready}, g[0] ? 2'b01 : 2'b10);
                g++;
            end
            if (fp_req0_ready || fp_req1_ready)
                chk("fp_grant", {fp_req0_ready, fp_req1_ready}, 2'b10);
            if (rsp0_valid) chk("rr_rsp0_data", rsp0_data, 8'h02);
            if (rsp1_valid) chk("rr_rsp1_data", rsp1_data, 8'h04);
            tick();
        end
        chk("rr_grant_count", (g >= 6), 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Asynchronous reset in the middle of a rotate.
        reset_pulse();
        run_txn(1'b0, 2'b00, 3'd1, 8'h81, 0);   // rsp0_data=02, rr now 1
        req0_op = 2'b10; req0_amt = 3'd3; req0_data = 8'h81; req0_valid = 1'b1;
        #1;
        chk("rot_ready", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        tick();
        chk("in_pass2_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        chk("arst_rsp0_data", rsp0_data, 8'h00);
        chk("arst_ready", {req0_ready, req1_ready}, 0);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        chk("no_rsp_after_rst", {rsp0_valid, rsp1_valid, busy}, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("post_rst_grant", {req0_ready, req1_ready}, 2'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
